booth_divider: RTL and testbench

// - Sequential signed integer divider: the inverse of the ALU's sequential Booth multiplier.
// - Computes quotient and remainder of dividend/divisor with the same start/done handshake.
// - Uses one restoring shift-subtract step per clock on operand magnitudes, then applies signs.
// - Sits beside the multiplier in the ALU datapath. Gives C semantics: truncate toward zero.

---
 rtl/div_pkg.sv | 10 +
 rtl/div_step.sv | 25 ++
 rtl/booth_divider.sv | 122 ++++++++++++
 tb/tb_booth_divider.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared encodings and sizing for the sequential signed divider.
package div_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int COUNT_W   = $clog2(DEF_WIDTH + 1);

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_ITER = 2'd1;
  localparam state_t S_FIX  = 2'd2;
endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] R_next,
  output logic [WIDTH-1:0] Q_next
);
  logic [WIDTH:0] sh;
  logic [WIDTH:0] t;

  always_comb begin
    sh = {R, Q[WIDTH-1]};
    t  = sh - {1'b0, D};
    if (!t[WIDTH]) begin
      R_next = t[WIDTH-1:0];
      Q_next = {Q[WIDTH-2:0], 1'b1};
    end else begin
      R_next = sh[WIDTH-1:0];
      Q_next = {Q[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider (truncating toward zero): one quotient bit per clock,
// signs applied in a final FIX cycle.
module booth_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d, qw_q, qw_d, d_q, d_d;
  logic             sq_q, sq_d, sr_q, sr_d, dbz_q, dbz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dbzo_q, dbzo_d, ovfo_q, ovfo_d, done_q, done_d;
  logic [WIDTH-1:0] r_nx, q_nx;

  div_step #(.WIDTH(WIDTH)) u_step (
    .R(r_q), .Q(qw_q), .D(d_q), .R_next(r_nx), .Q_next(q_nx)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    qw_d    = qw_q;
    d_d     = d_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbzo_d  = dbzo_q;
    ovfo_d  = ovfo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        qw_d    = dividend[WIDTH-1] ? -dividend : dividend;
        d_d     = divisor[WIDTH-1] ? -divisor : divisor;
        r_d     = '0;
        sq_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
        sr_d    = dividend[WIDTH-1];
        count_d = CW'(WIDTH);
        dbz_d   = (divisor == '0);
        ovf_d   = (dividend == INT_MIN) && (divisor == '1);
        state_d = (divisor == '0) ? S_FIX : S_ITER;
      end
      S_ITER: begin
        r_d     = r_nx;
        qw_d    = q_nx;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        // On divide-by-zero the working quotient still holds |dividend|,
        // so re-applying the dividend sign returns the dividend unchanged.
        quot_d  = dbz_q ? '1 : (sq_q ? -qw_q : qw_q);
        rem_d   = dbz_q ? (sr_q ? -qw_q : qw_q) : (sr_q ? -r_q : r_q);
        dbzo_d  = dbz_q;
        ovfo_d  = ovf_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      r_q     <= '0;
      qw_q    <= '0;
      d_q     <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbzo_q  <= 1'b0;
      ovfo_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      qw_q    <= qw_d;
      d_q     <= d_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbzo_q  <= dbzo_d;
      ovfo_q  <= ovfo_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbzo_q;
  assign overflow    = ovfo_q;
endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider: stimulus pushes expected results, a negedge monitor checks them.
module tb_booth_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_by_zero, overflow;

  booth_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".q"},   quotient, e.q);
        chk({e.name, ".r"},   remainder, e.r);
        chk({e.name, ".dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
        chk({e.name, ".ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
        chk({e.name, ".lat"}, cyc, e.cyc);
      end
    end
  end

  // Caller is positioned at a negedge; start is accepted on the following posedge.
  task automatic issue(input string name, input logic [31:0] dd, input logic [31:0] dv,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input logic eovf, input bit push);
    exp_t e;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf; e.name = name;
    e.cyc = cyc + (edbz ? 1 : 33);
    if (push) sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) chk({name, ".timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run(input string name, input logic [31:0] dd, input logic [31:0] dv,
                     input logic [31:0] eq, input logic [31:0] er,
                     input logic edbz, input logic eovf);
    @(negedge clk);
    issue(name, dd, dv, eq, er, edbz, eovf, 1'b1);
    wait_done(name);
  endtask

  initial begin
    bit seen;
    #12;
    chk("rst.q",    quotient, 32'd0);
    chk("rst.r",    remainder, 32'd0);
    chk("rst.ctl",  {28'd0, busy, done, div_by_zero, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("100/7",    32'd100,       32'd7,          32'd14,         32'd2,          1'b0, 1'b0);
    run("-100/7",   -32'sd100,     32'd7,          -32'sd14,       -32'sd2,        1'b0, 1'b0);
    run("100/-7",   32'd100,       -32'sd7,        -32'sd14,       32'd2,          1'b0, 1'b0);
    run("-100/-7",  -32'sd100,     -32'sd7,        32'd14,         -32'sd2,        1'b0, 1'b0);
    run("7/0",      32'd7,         32'd0,          32'hFFFF_FFFF,  32'd7,          1'b1, 1'b0);
    run("-7/0",     -32'sd7,       32'd0,          32'hFFFF_FFFF,  -32'sd7,        1'b1, 1'b0);
    run("min/-1",   32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1);
    run("min/1",    32'h8000_0000, 32'd1,          32'h8000_0000,  32'd0,          1'b0, 1'b0);
    run("0/5",      32'd0,         32'd5,          32'd0,          32'd0,          1'b0, 1'b0);

    // Starts while busy must be ignored.
    @(negedge clk);
    issue("ign", 32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    dividend = 32'd50; divisor = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 32'd0; divisor = 32'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("ign");

    // Back-to-back: accept in the done cycle, no lost cycle.
    issue("b2b", 32'd12345, 32'd100, 32'd123, 32'd45, 1'b0, 1'b0, 1'b1);
    wait_done("b2b");

    // Reset in the middle of ITER aborts with no done.
    @(negedge clk);
    issue("abort", 32'd77, 32'd5, 32'd15, 32'd2, 1'b0, 1'b0, 1'b0);
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst.q",   quotient, 32'd0);
    chk("arst.r",   remainder, 32'd0);
    chk("arst.ctl", {28'd0, busy, done, div_by_zero, overflow}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("arst.nodone", {31'd0, seen}, 32'd0);
    chk("arst.idle",   {31'd0, busy}, 32'd0);

    run("post_rst", -32'sd1000, 32'd7, -32'sd142, -32'sd6, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
